// File: rtl/keypad_divider_top.sv
// keypad_divider_top -- 8-bit hex divider calculator.
//
// Purpose:
//   Two 2-digit hex operands are typed on a 4x4 keypad. A sequential restoring
//   divider produces the quotient and remainder, and a 4-digit multiplexed
//   7-segment display shows the operands or the selected result.
//
// Ports:
//   clk_27mhz      in   system clock
//   reset_n        in   asynchronous active-low reset
//   keypad_rows    in   [3:0] keypad rows, active-low, idle 4'b1111
//   keypad_cols    out  [3:0] column drive, one-hot active-low
//   btn_div        in   operand A done, start operand B
//   btn_quot       in   divide and show the quotient
//   btn_rem        in   divide and show the remainder
//   btn_clear      in   clear everything
//   segmentos_out  out  [7:0] {dp,g,f,e,d,c,b,a}, active-low
//   anodos_out     out  [3:0] digit enables, active-low, bit 0 = rightmost
//
// Build option:
//   DIV0_ERR_EN  when defined, a divide by zero shows "Err" until cleared.
//                When undefined, it yields quotient FF and remainder = dividend.

module keypad_divider_top #(
  parameter int SCAN_CYCLES     = 27_000,
  parameter int DEBOUNCE_CYCLES = 270_000,
  parameter int REFRESH_CYCLES  = 27_000
) (
  input  logic       clk_27mhz,
  input  logic       reset_n,
  input  logic [3:0] keypad_rows,
  output logic [3:0] keypad_cols,
  input  logic       btn_div,
  input  logic       btn_quot,
  input  logic       btn_rem,
  input  logic       btn_clear,
  output logic [7:0] segmentos_out,
  output logic [3:0] anodos_out
);

  localparam int SCW = $clog2(SCAN_CYCLES + 1);
  localparam int DBW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RFW = $clog2(REFRESH_CYCLES + 1);

  // ---------------------------------------------------------------- sync
  logic [3:0] rows_m_q, rows_s_q;
  logic [3:0] btn_m_q, btn_s_q;   // {clear, rem, quot, div}

  always_ff @(posedge clk_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      rows_m_q <= 4'hF;
      rows_s_q <= 4'hF;
      btn_m_q  <= 4'h0;
      btn_s_q  <= 4'h0;
    end else begin
      rows_m_q <= keypad_rows;
      rows_s_q <= rows_m_q;
      btn_m_q  <= {btn_clear, btn_rem, btn_quot, btn_div};
      btn_s_q  <= btn_m_q;
    end
  end

  // ----------------------------------------------------- button debounce
  logic [3:0] btn_pulse;

  for (genvar gi = 0; gi < 4; gi++) begin : g_btn
    logic [DBW-1:0] cnt_q;
    logic           lvl_q;
    logic           pulse_q;

    always_ff @(posedge clk_27mhz or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q   <= '0;
        lvl_q   <= 1'b0;
        pulse_q <= 1'b0;
      end else begin
        pulse_q <= 1'b0;
        if (btn_s_q[gi] == lvl_q) begin
          cnt_q <= '0;
        end else if (cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
          cnt_q   <= '0;
          lvl_q   <= btn_s_q[gi];
          pulse_q <= btn_s_q[gi];   // only the accepted rising edge pulses
        end else begin
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end

    assign btn_pulse[gi] = pulse_q;
  end

  // Only the highest-priority button acts in a given cycle.
  logic clr_p, div_p, quot_p, rem_p;
  assign clr_p  = btn_pulse[3];
  assign div_p  = btn_pulse[0] & ~clr_p;
  assign quot_p = btn_pulse[1] & ~clr_p & ~btn_pulse[0];
  assign rem_p  = btn_pulse[2] & ~clr_p & ~btn_pulse[0] & ~btn_pulse[1];

  // ----------------------------------------------------- keypad scanner
  typedef enum logic [1:0] {K_SCAN, K_DEB, K_REL} kstate_e;

  kstate_e        kst_q;
  logic [1:0]     col_q;
  logic [SCW-1:0] scan_cnt_q;
  logic [DBW-1:0] kdeb_cnt_q;
  logic [3:0]     krow_q;
  logic           key_vld_q;
  logic [3:0]     key_val_q;

  function automatic logic [3:0] key_decode(input logic [3:0] rows_n, input logic [1:0] col);
    logic [1:0] row;
    logic [3:0] k;
    if (!rows_n[0])      row = 2'd0;
    else if (!rows_n[1]) row = 2'd1;
    else if (!rows_n[2]) row = 2'd2;
    else                 row = 2'd3;
    case ({row, col})
      4'h0: k = 4'h1;  4'h1: k = 4'h2;  4'h2: k = 4'h3;  4'h3: k = 4'hA;
      4'h4: k = 4'h4;  4'h5: k = 4'h5;  4'h6: k = 4'h6;  4'h7: k = 4'hB;
      4'h8: k = 4'h7;  4'h9: k = 4'h8;  4'hA: k = 4'h9;  4'hB: k = 4'hC;
      4'hC: k = 4'hE;  4'hD: k = 4'h0;  4'hE: k = 4'hF;  default: k = 4'hD;
    endcase
    return k;
  endfunction

  // The column is held still from the first low row until the key has been
  // released and stable, so the decoded column always matches the row.
  always_ff @(posedge clk_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      kst_q      <= K_SCAN;
      col_q      <= 2'd0;
      scan_cnt_q <= '0;
      kdeb_cnt_q <= '0;
      krow_q     <= 4'hF;
      key_vld_q  <= 1'b0;
      key_val_q  <= 4'h0;
    end else begin
      key_vld_q <= 1'b0;
      case (kst_q)
        K_SCAN: begin
          if (rows_s_q != 4'hF) begin
            kst_q      <= K_DEB;
            kdeb_cnt_q <= '0;
            krow_q     <= rows_s_q;
            scan_cnt_q <= '0;
          end else if (scan_cnt_q == SCW'(SCAN_CYCLES - 1)) begin
            scan_cnt_q <= '0;
            col_q      <= col_q + 2'd1;
          end else begin
            scan_cnt_q <= scan_cnt_q + 1'b1;
          end
        end
        K_DEB: begin
          if (rows_s_q == 4'hF) begin
            kst_q <= K_SCAN;                    // bounce or stale row: resume scanning
          end else if (rows_s_q != krow_q) begin
            krow_q     <= rows_s_q;             // pattern changed: restart stability window
            kdeb_cnt_q <= '0;
          end else if (kdeb_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
            key_vld_q  <= 1'b1;
            key_val_q  <= key_decode(rows_s_q, col_q);
            kst_q      <= K_REL;
            kdeb_cnt_q <= '0;
          end else begin
            kdeb_cnt_q <= kdeb_cnt_q + 1'b1;
          end
        end
        K_REL: begin
          if (rows_s_q != 4'hF) begin
            kdeb_cnt_q <= '0;
          end else if (kdeb_cnt_q == DBW'(DEBOUNCE_CYCLES - 1)) begin
            kst_q      <= K_SCAN;
            kdeb_cnt_q <= '0;
          end else begin
            kdeb_cnt_q <= kdeb_cnt_q + 1'b1;
          end
        end
        default: kst_q <= K_SCAN;
      endcase
    end
  end

  assign keypad_cols = ~(4'b0001 << col_q);

  // ------------------------------------------------- calculator + divider
  typedef enum logic [1:0] {ENTER_A, ENTER_B, DIVIDING, SHOW} state_e;

  state_e     state_q;
  logic [7:0] num1_q, num2_q;
  logic [7:0] quo_q, rem_q;      // quo_q starts as the dividend and shifts into the quotient
  logic [3:0] div_cnt_q;
  logic       sel_rem_q;
`ifdef DIV0_ERR_EN
  logic       err_q;
`endif

  logic [8:0] div_shift;
  logic [7:0] div_diff;
  logic       div_ge;
  assign div_shift = {rem_q, quo_q[7]};
  assign div_ge    = (div_shift >= {1'b0, num2_q});
  // When the subtraction is taken the difference is below the divisor, so 8 bits suffice.
  assign div_diff  = div_shift[7:0] - num2_q;

  always_ff @(posedge clk_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ENTER_A;
      num1_q    <= 8'h00;
      num2_q    <= 8'h00;
      quo_q     <= 8'h00;
      rem_q     <= 8'h00;
      div_cnt_q <= 4'd0;
      sel_rem_q <= 1'b0;
`ifdef DIV0_ERR_EN
      err_q     <= 1'b0;
`endif
    end else if (clr_p) begin
      state_q   <= ENTER_A;
      num1_q    <= 8'h00;
      num2_q    <= 8'h00;
      sel_rem_q <= 1'b0;
`ifdef DIV0_ERR_EN
      err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        ENTER_A: begin
          if (div_p) begin
            state_q <= ENTER_B;
            num2_q  <= 8'h00;
          end else if (key_vld_q) begin
            num1_q <= {num1_q[3:0], key_val_q};
          end
        end
        ENTER_B: begin
          if (quot_p || rem_p) begin
            sel_rem_q <= rem_p;
            quo_q     <= num1_q;
            rem_q     <= 8'h00;
            div_cnt_q <= 4'd0;
            state_q   <= DIVIDING;
          end else if (key_vld_q) begin
            num2_q <= {num2_q[3:0], key_val_q};
          end
        end
        DIVIDING: begin
          if (num2_q == 8'h00) begin
            quo_q   <= 8'hFF;
            rem_q   <= num1_q;
            state_q <= SHOW;
`ifdef DIV0_ERR_EN
            err_q   <= 1'b1;
`endif
          end else if (div_cnt_q == 4'd8) begin
            state_q <= SHOW;                    // ninth clock: completion
          end else begin
            if (div_ge) begin
              rem_q <= div_diff;
              quo_q <= {quo_q[6:0], 1'b1};
            end else begin
              rem_q <= div_shift[7:0];
              quo_q <= {quo_q[6:0], 1'b0};
            end
            div_cnt_q <= div_cnt_q + 4'd1;
          end
        end
        SHOW: begin
          if (quot_p)     sel_rem_q <= 1'b0;
          else if (rem_p) sel_rem_q <= 1'b1;
        end
        default: state_q <= ENTER_A;
      endcase
    end
  end

  // ------------------------------------------------------------ display
  function automatic logic [6:0] hex_font(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'h0: s = 7'h40; 4'h1: s = 7'h79; 4'h2: s = 7'h24; 4'h3: s = 7'h30;
      4'h4: s = 7'h19; 4'h5: s = 7'h12; 4'h6: s = 7'h02; 4'h7: s = 7'h78;
      4'h8: s = 7'h00; 4'h9: s = 7'h10; 4'hA: s = 7'h08; 4'hB: s = 7'h03;
      4'hC: s = 7'h46; 4'hD: s = 7'h21; 4'hE: s = 7'h06; default: s = 7'h0E;
    endcase
    return s;
  endfunction

  logic [RFW-1:0] ref_cnt_q;
  logic [1:0]     slot_q;
  logic [7:0]     seg_q, seg_d, seg_norm;
  logic [3:0]     an_q, an_d;
  logic [3:0]     disp_nib;
  logic           disp_blank, disp_dp;
  logic [7:0]     result;

  assign result = sel_rem_q ? rem_q : quo_q;

  always_comb begin
    disp_nib   = 4'h0;
    disp_blank = 1'b1;
    disp_dp    = 1'b0;
    case (state_q)
      ENTER_A: begin
        if (slot_q == 2'd0)      begin disp_nib = num1_q[3:0]; disp_blank = 1'b0; end
        else if (slot_q == 2'd1) begin disp_nib = num1_q[7:4]; disp_blank = 1'b0; end
      end
      ENTER_B, DIVIDING: begin
        disp_blank = 1'b0;
        case (slot_q)
          2'd0:    disp_nib = num2_q[3:0];
          2'd1:    disp_nib = num2_q[7:4];
          2'd2:    disp_nib = num1_q[3:0];
          default: disp_nib = num1_q[7:4];
        endcase
      end
      SHOW: begin
        if (slot_q == 2'd0) begin
          disp_nib   = result[3:0];
          disp_blank = 1'b0;
          disp_dp    = sel_rem_q;
        end else if (slot_q == 2'd1) begin
          disp_nib   = result[7:4];
          disp_blank = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign seg_norm = disp_blank ? 8'hFF : {~disp_dp, hex_font(disp_nib)};

`ifdef DIV0_ERR_EN
  // "Err" overrides the result until a clear.
  always_comb begin
    seg_d = seg_norm;
    if (state_q == SHOW && err_q) begin
      case (slot_q)
        2'd3:    seg_d = 8'hFF;
        2'd2:    seg_d = 8'b1000_0110;
        default: seg_d = 8'b1010_1111;
      endcase
    end
  end
`else
  assign seg_d = seg_norm;
`endif

  assign an_d = ~(4'b0001 << slot_q);

  always_ff @(posedge clk_27mhz or negedge reset_n) begin
    if (!reset_n) begin
      ref_cnt_q <= '0;
      slot_q    <= 2'd0;
      an_q      <= 4'hF;
      seg_q     <= 8'hFF;
    end else begin
      if (ref_cnt_q == RFW'(REFRESH_CYCLES - 1)) begin
        ref_cnt_q <= '0;
        slot_q    <= slot_q + 2'd1;
      end else begin
        ref_cnt_q <= ref_cnt_q + 1'b1;
      end
      an_q  <= an_d;
      seg_q <= seg_d;
    end
  end

  assign anodos_out    = an_q;
  assign segmentos_out = seg_q;

endmodule

// File: tb/tb_keypad_divider_top.sv
module tb_keypad_divider_top;

  localparam int SCAN = 4;
  localparam int DEB  = 4;
  localparam int REF  = 4;

  localparam int ST_A = 0, ST_B = 1, ST_DIV = 2, ST_SHOW = 3;
  localparam int B_DIV = 0, B_QUOT = 1, B_REM = 2, B_CLR = 3;

  // Physical keypad layout, row-major (row 0 first).
  localparam logic [3:0] LAYOUT [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                                         4'h4, 4'h5, 4'h6, 4'hB,
                                         4'h7, 4'h8, 4'h9, 4'hC,
                                         4'hE, 4'h0, 4'hF, 4'hD};
  // Standard active-low hex glyphs {dp,g,f,e,d,c,b,a}, dp off.
  localparam logic [7:0] FONT [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                       8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic       clk_27mhz = 1'b0;
  logic       reset_n   = 1'b0;
  logic [3:0] keypad_rows;
  logic [3:0] keypad_cols;
  logic       btn_div = 1'b0, btn_quot = 1'b0, btn_rem = 1'b0, btn_clear = 1'b0;
  logic [7:0] segmentos_out;
  logic [3:0] anodos_out;

  always #5 clk_27mhz = ~clk_27mhz;

  keypad_divider_top #(
    .SCAN_CYCLES(SCAN), .DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF)
  ) dut (
    .clk_27mhz(clk_27mhz), .reset_n(reset_n),
    .keypad_rows(keypad_rows), .keypad_cols(keypad_cols),
    .btn_div(btn_div), .btn_quot(btn_quot), .btn_rem(btn_rem), .btn_clear(btn_clear),
    .segmentos_out(segmentos_out), .anodos_out(anodos_out)
  );

  // Keypad switch matrix: a held key pulls its row low only while its column is driven.
  logic       key_en = 1'b0;
  logic [1:0] key_r = 2'd0, key_c = 2'd0;
  always_comb begin
    keypad_rows = 4'hF;
    if (key_en && keypad_cols[key_c] == 1'b0) keypad_rows[key_r] = 1'b0;
  end

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the calculator.
  int         m_state   = ST_A;
  logic [7:0] m_num1    = 8'h00;
  logic [7:0] m_num2    = 8'h00;
  bit         m_sel_rem = 1'b0;
  bit         check_en  = 1'b0;

  function automatic logic [7:0] exp_seg(input int slot);
    logic [7:0] res;
    bit         err;
    exp_seg = 8'hFF;
    err = 1'b0;
`ifdef DIV0_ERR_EN
    err = (m_num2 == 8'h00);
`endif
    case (m_state)
      ST_A: begin
        if (slot == 0)      exp_seg = FONT[m_num1[3:0]];
        else if (slot == 1) exp_seg = FONT[m_num1[7:4]];
      end
      ST_B, ST_DIV: begin
        case (slot)
          0:       exp_seg = FONT[m_num2[3:0]];
          1:       exp_seg = FONT[m_num2[7:4]];
          2:       exp_seg = FONT[m_num1[3:0]];
          default: exp_seg = FONT[m_num1[7:4]];
        endcase
      end
      default: begin
        if (err) begin
          if (slot == 2)     exp_seg = 8'h86;
          else if (slot < 2) exp_seg = 8'hAF;
        end else begin
          if (m_num2 == 8'h00) res = m_sel_rem ? m_num1 : 8'hFF;
          else                 res = m_sel_rem ? (m_num1 % m_num2) : (m_num1 / m_num2);
          if (slot == 0)      exp_seg = FONT[res[3:0]] & (m_sel_rem ? 8'h7F : 8'hFF);
          else if (slot == 1) exp_seg = FONT[res[7:4]];
        end
      end
    endcase
  endfunction

  // Per-cycle compare of the display against the model, plus refresh rotation.
  logic [3:0] an_prev = 4'hF;
  int         run_len = 0;
  int         n_changes = 0;

  always @(negedge clk_27mhz) begin
    int         slot;
    logic [3:0] oh;
    if (!reset_n) begin
      an_prev   = 4'hF;
      run_len   = 0;
      n_changes = 0;
    end else begin
      if (anodos_out != an_prev) begin
        if (n_changes >= 1) begin
          n_checks++;
          if (run_len != REF || anodos_out != {an_prev[2:0], an_prev[3]}) begin
            n_fail++;
            $display("FAIL refresh_rotation: got %b after %b held %0d cycles, required %b held %0d",
                     anodos_out, an_prev, run_len, {an_prev[2:0], an_prev[3]}, REF);
          end
        end
        n_changes++;
        run_len = 1;
        an_prev = anodos_out;
      end else begin
        run_len++;
      end

      if (check_en) begin
        slot = -1;
        for (int i = 0; i < 4; i++) begin
          oh = 4'b0001 << i;
          if (anodos_out == ~oh) slot = i;
        end
        n_checks++;
        if (slot < 0) begin
          n_fail++;
          $display("FAIL anode_onehot: got %b, required one-hot active-low", anodos_out);
        end else if (segmentos_out !== exp_seg(slot)) begin
          n_fail++;
          $display("FAIL seg_slot%0d: got %h, required %h (state %0d num1 %h num2 %h rem %0d)",
                   slot, segmentos_out, exp_seg(slot), m_state, m_num1, m_num2, m_sel_rem);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_27mhz);
  endtask

  task automatic press_key(input logic [3:0] d, input int hold);
    int         idx;
    logic [3:0] oh;
    logic [3:0] col_seen;
    idx = 0;
    for (int i = 0; i < 16; i++) if (LAYOUT[i] == d) idx = i;
    check_en = 1'b0;
    @(negedge clk_27mhz);
    key_r  = 2'(idx / 4);
    key_c  = 2'(idx % 4);
    key_en = 1'b1;
    cyc(40);
    oh = 4'b0001 << key_c;
    n_checks++;
    if (keypad_cols !== ~oh) begin
      n_fail++;
      $display("FAIL col_on_key %h: got %b, required %b", d, keypad_cols, ~oh);
    end
    col_seen = keypad_cols;
    cyc(hold);
    n_checks++;
    if (keypad_cols !== col_seen) begin
      n_fail++;
      $display("FAIL col_frozen %h: got %b, required %b", d, keypad_cols, col_seen);
    end
    key_en = 1'b0;
    cyc(40);
    if (m_state == ST_A)      m_num1 = {m_num1[3:0], d};
    else if (m_state == ST_B) m_num2 = {m_num2[3:0], d};
    $display("key %h -> state %0d num1 %h num2 %h", d, m_state, m_num1, m_num2);
    check_en = 1'b1;
  endtask

  task automatic set_btn(input int b, input logic v);
    case (b)
      B_DIV:   btn_div   = v;
      B_QUOT:  btn_quot  = v;
      B_REM:   btn_rem   = v;
      default: btn_clear = v;
    endcase
  endtask

  task automatic press_btn(input int b);
    check_en = 1'b0;
    @(negedge clk_27mhz);
    set_btn(b, 1'b1);
    cyc(30);
    set_btn(b, 1'b0);
    cyc(30);
    case (b)
      B_CLR: begin
        m_state = ST_A; m_num1 = 8'h00; m_num2 = 8'h00; m_sel_rem = 1'b0;
      end
      B_DIV: if (m_state == ST_A) begin m_state = ST_B; m_num2 = 8'h00; end
      default: begin
        if (m_state == ST_B) begin
          m_state = ST_SHOW; m_sel_rem = (b == B_REM);
        end else if (m_state == ST_SHOW) begin
          m_sel_rem = (b == B_REM);
        end
      end
    endcase
    $display("btn %0d -> state %0d num1 %h num2 %h rem_sel %0d", b, m_state, m_num1, m_num2, m_sel_rem);
    check_en = 1'b1;
  endtask

  // Hand-computed display expectation for one digit slot.
  task automatic lit(input int slot, input logic [7:0] v, input string name);
    logic [3:0] oh;
    bit         found;
    oh = 4'b0001 << slot;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk_27mhz);
      if (anodos_out == ~oh) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_fail++;
      $display("FAIL %s: slot %0d never enabled, anodes %b", name, slot, anodos_out);
    end else if (segmentos_out !== v) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, segmentos_out, v);
    end
  endtask

  task automatic check_reset_vals(input string name);
    n_checks += 3;
    if (keypad_cols !== 4'b1110) begin
      n_fail++; $display("FAIL %s cols: got %b, required 1110", name, keypad_cols);
    end
    if (anodos_out !== 4'b1111) begin
      n_fail++; $display("FAIL %s anodes: got %b, required 1111", name, anodos_out);
    end
    if (segmentos_out !== 8'hFF) begin
      n_fail++; $display("FAIL %s segs: got %h, required ff", name, segmentos_out);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] a, b;
    int         op;

    cyc(3);
    check_reset_vals("reset");
    reset_n = 1'b1;
    cyc(10);
    check_en = 1'b1;
    lit(0, 8'hC0, "reset_d0");
    lit(2, 8'hFF, "reset_d2");

    // C8 / 32
    press_key(4'hC, 10); press_key(4'h8, 10);
    press_btn(B_DIV);
    press_key(4'h3, 10); press_key(4'h2, 10);
    lit(3, 8'hC6, "entb_d3");
    lit(2, 8'h80, "entb_d2");
    press_btn(B_QUOT);
    lit(0, 8'h99, "c8_quot_d0");
    lit(1, 8'hC0, "c8_quot_d1");
    lit(2, 8'hFF, "c8_quot_d2");
    press_btn(B_REM);
    lit(0, 8'h40, "c8_rem_d0");
    lit(1, 8'hC0, "c8_rem_d1");
    press_key(4'h5, 10);             // ignored in SHOW
    press_btn(B_DIV);                // ignored in SHOW
    press_btn(B_CLR);
    lit(0, 8'hC0, "clear_d0");
    lit(1, 8'hC0, "clear_d1");
    lit(3, 8'hFF, "clear_d3");

    // Only the last two digits survive.
    press_key(4'h1, 10); press_key(4'h2, 10); press_key(4'h3, 10);
    lit(1, 8'hA4, "123_d1");
    lit(0, 8'hB0, "123_d0");
    press_btn(B_CLR);

    // FF % 10 = 0F
    press_key(4'hF, 10); press_key(4'hF, 10);
    press_btn(B_DIV);
    press_key(4'h1, 10); press_key(4'h0, 10);
    press_btn(B_REM);
    lit(0, 8'h0E, "ff_rem_d0");
    lit(1, 8'hC0, "ff_rem_d1");
    press_btn(B_CLR);

    // 7 / 0
    press_key(4'h7, 10);
    press_btn(B_DIV);
    press_key(4'h0, 10);
    press_btn(B_QUOT);
`ifdef DIV0_ERR_EN
    lit(0, 8'hAF, "div0_d0");
    lit(1, 8'hAF, "div0_d1");
    lit(2, 8'h86, "div0_d2");
    lit(3, 8'hFF, "div0_d3");
`else
    lit(0, 8'h8E, "div0_d0");
    lit(1, 8'h8E, "div0_d1");
    press_btn(B_REM);
    lit(0, 8'h78, "div0_rem_d0");
    lit(1, 8'hC0, "div0_rem_d1");
`endif
    press_btn(B_CLR);

    // Long hold across many scan periods: exactly one digit entered.
    press_key(4'h5, 40);
    lit(0, 8'h92, "hold_d0");
    lit(1, 8'hC0, "hold_d1");

    // Randomized operations against the model.
    for (int it = 0; it < 10; it++) begin
      a = 8'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      op = $urandom_range(0, 1) ? B_QUOT : B_REM;
      press_btn(B_CLR);
      press_key(a[7:4], 10); press_key(a[3:0], 10);
      press_btn(B_DIV);
      press_key(b[7:4], 10); press_key(b[3:0], 10);
      press_btn(op);
      cyc(20);
      if ($urandom_range(0, 1)) begin
        press_btn(op == B_QUOT ? B_REM : B_QUOT);
        cyc(20);
      end
      if ($urandom_range(0, 1)) press_key(4'($urandom_range(0, 15)), 10);
    end

    // Reset while the divider is running.
    press_btn(B_CLR);
    press_key(4'h9, 10); press_key(4'h6, 10);
    press_btn(B_DIV);
    press_key(4'h0, 10); press_key(4'h5, 10);
    check_en = 1'b0;
    @(negedge clk_27mhz);
    btn_quot = 1'b1;
    cyc(10);
    #2 reset_n = 1'b0;
    #1 check_reset_vals("reset_mid_div");
    btn_quot = 1'b0;
    m_state = ST_A; m_num1 = 8'h00; m_num2 = 8'h00; m_sel_rem = 1'b0;
    cyc(3);
    reset_n = 1'b1;
    cyc(10);
    check_en = 1'b1;
    lit(0, 8'hC0, "after_reset_d0");
    lit(2, 8'hFF, "after_reset_d2");
    cyc(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
